// File: rtl/dxl_status_rx_if.sv
// Status-packet result bus from the Dynamixel receive engine to the register logic.
// The engine drives it through the master modport; consumers use slave.
interface dxl_status_rx_if;
  logic        status_valid;
  logic [7:0]  status_id;
  logic [7:0]  status_error;
  logic [31:0] status_data;
  logic [7:0]  status_param_count;
  logic        crc_error;
  logic        frame_error;
  logic        timeout;

  modport master (
    output status_valid, status_id, status_error, status_data,
           status_param_count, crc_error, frame_error, timeout
  );

  modport slave (
    input status_valid, status_id, status_error, status_data,
          status_param_count, crc_error, frame_error, timeout
  );
endinterface

// File: rtl/dxl_status_rx.sv
// Dynamixel 2.0 status-packet receiver: 8N1 oversampling UART, header/field parser,
// byte unstuffing, CRC-16 check and result capture.
module dxl_status_rx #(
  parameter int unsigned CLKS_PER_BIT = 50,
  parameter int unsigned MAX_LEN      = 64,
  parameter int unsigned TIMEOUT_CLKS = 5000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rx,
  dxl_status_rx_if.master bus
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [15:0]   LEN_MIN = 16'd4;
  localparam logic [15:0]   LEN_MAX = 16'(MAX_LEN);
  localparam logic [7:0]    INST_STATUS = 8'h55;

  typedef enum logic [2:0] {
    U_IDLE, U_START, U_DATA, U_STOP, U_BREAK
  } uart_state_t;

  typedef enum logic [3:0] {
    P_HDR0, P_HDR1, P_HDR2, P_RSV, P_ID, P_LEN_L, P_LEN_H,
    P_INST, P_ERR, P_PARAM, P_CRC_L, P_CRC_H
  } parse_state_t;

  // ---------------------------------------------------------------- UART
  uart_state_t   ust;
  logic [CW-1:0] ucnt;
  logic [2:0]    ubit;
  logic [7:0]    ushift;
  logic          rx_meta;
  logic          rx_sync;
  logic          byte_stb;
  logic [7:0]    byte_data;
  logic          frame_err;

  // After a low stop bit the line may still be low (break); wait for idle before hunting a start.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      ust       <= U_IDLE;
      ucnt      <= '0;
      ubit      <= '0;
      ushift    <= '0;
      byte_stb  <= 1'b0;
      byte_data <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      case (ust)
        U_IDLE: begin
          ucnt <= '0;
          if (!rx_sync) ust <= U_START;
        end
        U_START: begin
          if (ucnt == HALF_M1) begin
            ucnt <= '0;
            ubit <= '0;
            ust  <= rx_sync ? U_IDLE : U_DATA;
          end else begin
            ucnt <= ucnt + CW'(1);
          end
        end
        U_DATA: begin
          if (ucnt == FULL_M1) begin
            ucnt   <= '0;
            ushift <= {rx_sync, ushift[7:1]};
            ubit   <= ubit + 3'd1;
            if (ubit == 3'd7) ust <= U_STOP;
          end else begin
            ucnt <= ucnt + CW'(1);
          end
        end
        U_STOP: begin
          if (ucnt == FULL_M1) begin
            ucnt <= '0;
            if (rx_sync) begin
              byte_stb  <= 1'b1;
              byte_data <= ushift;
              ust       <= U_IDLE;
            end else begin
              frame_err <= 1'b1;
              ust       <= U_BREAK;
            end
          end else begin
            ucnt <= ucnt + CW'(1);
          end
        end
        U_BREAK: begin
          if (rx_sync) ust <= U_IDLE;
        end
        default: ust <= U_IDLE;
      endcase
    end
  end

  assign bus.frame_error = frame_err;

  // ---------------------------------------------------------------- CRC
  function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  parse_state_t  pst;
  logic [15:0]   crc;
  logic [7:0]    len_l;
  logic [15:0]   raw_left;
  logic [7:0]    hist0;
  logic [7:0]    hist1;
  logic [7:0]    hist2;
  logic [7:0]    crc_l;
  logic [7:0]    sh_id;
  logic [7:0]    sh_err;
  logic [7:0]    sh_cnt;
  logic [31:0]   sh_data;
  logic [TW-1:0] to_cnt;

  logic [15:0] crc_seed_c;
  logic [15:0] crc_next_c;
  logic [15:0] len_full_c;
  logic        stuffed_c;

  // The first header byte restarts the CRC from zero.
  always_comb begin
    crc_seed_c = (pst == P_HDR0) ? 16'h0000 : crc;
    crc_next_c = crc_fold(crc_seed_c, byte_data);
    len_full_c = {byte_data, len_l};
    stuffed_c  = (pst == P_PARAM) && (hist2 == 8'hFF) && (hist1 == 8'hFF) &&
                 (hist0 == 8'hFD) && (byte_data == 8'hFD);
  end

  // ---------------------------------------------------------------- parser
  always_ff @(posedge clock) begin
    if (reset) begin
      pst                    <= P_HDR0;
      crc                    <= '0;
      len_l                  <= '0;
      raw_left               <= '0;
      hist0                  <= '0;
      hist1                  <= '0;
      hist2                  <= '0;
      crc_l                  <= '0;
      sh_id                  <= '0;
      sh_err                 <= '0;
      sh_cnt                 <= '0;
      sh_data                <= '0;
      to_cnt                 <= '0;
      bus.status_valid       <= 1'b0;
      bus.status_id          <= '0;
      bus.status_error       <= '0;
      bus.status_data        <= '0;
      bus.status_param_count <= '0;
      bus.crc_error          <= 1'b0;
      bus.timeout            <= 1'b0;
    end else begin
      bus.status_valid <= 1'b0;
      bus.crc_error    <= 1'b0;
      bus.timeout      <= 1'b0;
      if (frame_err) begin
        pst    <= P_HDR0;
        to_cnt <= '0;
      end else if (byte_stb) begin
        to_cnt <= '0;
        case (pst)
          P_HDR0: begin
            if (byte_data == 8'hFF) begin
              pst <= P_HDR1;
              crc <= crc_next_c;
            end
          end
          P_HDR1: begin
            if (byte_data == 8'hFF) begin
              pst <= P_HDR2;
              crc <= crc_next_c;
            end else begin
              pst <= P_HDR0;
            end
          end
          // Extra FF keeps the CRC of the last two FFs, which is unchanged.
          P_HDR2: begin
            if (byte_data == 8'hFD) begin
              pst <= P_RSV;
              crc <= crc_next_c;
            end else if (byte_data != 8'hFF) begin
              pst <= P_HDR0;
            end
          end
          P_RSV: begin
            if (byte_data == 8'h00) begin
              pst <= P_ID;
              crc <= crc_next_c;
            end else begin
              pst <= P_HDR0;
            end
          end
          P_ID: begin
            sh_id <= byte_data;
            crc   <= crc_next_c;
            pst   <= P_LEN_L;
          end
          P_LEN_L: begin
            len_l <= byte_data;
            crc   <= crc_next_c;
            pst   <= P_LEN_H;
          end
          P_LEN_H: begin
            crc <= crc_next_c;
            if (len_full_c < LEN_MIN || len_full_c > LEN_MAX) begin
              pst <= P_HDR0;
            end else begin
              raw_left <= len_full_c - LEN_MIN;
              pst      <= P_INST;
            end
          end
          P_INST: begin
            if (byte_data == INST_STATUS) begin
              crc <= crc_next_c;
              pst <= P_ERR;
            end else begin
              pst <= P_HDR0;
            end
          end
          P_ERR: begin
            sh_err  <= byte_data;
            crc     <= crc_next_c;
            sh_data <= '0;
            sh_cnt  <= '0;
            hist0   <= '0;
            hist1   <= '0;
            hist2   <= '0;
            pst     <= (raw_left == 16'd0) ? P_CRC_L : P_PARAM;
          end
          P_PARAM: begin
            crc      <= crc_next_c;
            hist0    <= byte_data;
            hist1    <= hist0;
            hist2    <= hist1;
            raw_left <= raw_left - 16'd1;
            if (!stuffed_c) begin
              if (sh_cnt < 8'd4) sh_data[{sh_cnt[1:0], 3'b000} +: 8] <= byte_data;
              if (sh_cnt != 8'hFF) sh_cnt <= sh_cnt + 8'd1;
            end
            if (raw_left == 16'd1) pst <= P_CRC_L;
          end
          P_CRC_L: begin
            crc_l <= byte_data;
            pst   <= P_CRC_H;
          end
          P_CRC_H: begin
            pst <= P_HDR0;
            if ({byte_data, crc_l} == crc) begin
              bus.status_valid       <= 1'b1;
              bus.status_id          <= sh_id;
              bus.status_error       <= sh_err;
              bus.status_data        <= sh_data;
              bus.status_param_count <= sh_cnt;
            end else begin
              bus.crc_error <= 1'b1;
            end
          end
          default: pst <= P_HDR0;
        endcase
      end else if (pst != P_HDR0) begin
        if (to_cnt == TO_M1) begin
          bus.timeout <= 1'b1;
          pst         <= P_HDR0;
          to_cnt      <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dxl_status_rx.sv
// Scoreboard bench for dxl_status_rx: serialises packets onto rx, queues the expected
// pulse and status payload, and checks them when the DUT pulses.
`timescale 1ns/1ps
module tb_dxl_status_rx;

  localparam int unsigned CPB  = 16;
  localparam int unsigned MAXL = 300;
  localparam int unsigned TOC  = 400;

  localparam logic [3:0] K_VALID = 4'b1000;
  localparam logic [3:0] K_CRC   = 4'b0100;
  localparam logic [3:0] K_FRAME = 4'b0010;
  localparam logic [3:0] K_TO    = 4'b0001;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;

  dxl_status_rx_if bus ();

  dxl_status_rx #(
    .CLKS_PER_BIT(CPB),
    .MAX_LEN     (MAXL),
    .TIMEOUT_CLKS(TOC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx   (rx),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  kind;
    logic [7:0]  id;
    logic [7:0]  err;
    logic [31:0] data;
    logic [7:0]  cnt;
  } exp_t;

  exp_t       sbq[$];
  exp_t       last_good;
  exp_t       mon_e;
  logic [7:0] pkt[$];
  logic [7:0] tmp[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // CRC by polynomial long division of the message augmented with 16 zero bits.
  function automatic logic [15:0] ref_crc();
    logic [15:0] r;
    logic        top;
    logic        bitv;
    int          n;
    r = 16'h0000;
    n = pkt.size();
    for (int i = 0; i < n + 2; i++) begin
      for (int b = 7; b >= 0; b--) begin
        bitv = (i < n) ? pkt[i][b] : 1'b0;
        top  = r[15];
        r    = {r[14:0], bitv};
        if (top) r = r ^ 16'h8005;
      end
    end
    return r;
  endfunction

  task automatic seal(input logic corrupt);
    logic [15:0] c;
    c = ref_crc();
    pkt.push_back(c[7:0]);
    pkt.push_back(c[15:8] ^ (corrupt ? 8'h01 : 8'h00));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clock);
    end
    rx = stop;
    repeat (CPB) @(posedge clock);
    rx = 1'b1;
    if (!stop) repeat (2 * CPB) @(posedge clock);
  endtask

  task automatic send_pkt(input int n, input int bad_idx);
    for (int i = 0; i < n; i++) send_byte(pkt[i], (i != bad_idx));
  endtask

  task automatic expect_pulse(input logic [3:0] k, input logic [7:0] id, input logic [7:0] err,
                              input logic [31:0] d, input logic [7:0] c);
    exp_t e;
    e.kind = k; e.id = id; e.err = err; e.data = d; e.cnt = c;
    sbq.push_back(e);
    if (k == K_VALID) last_good = e;
  endtask

  task automatic expect_hold(input logic [3:0] k);
    expect_pulse(k, last_good.id, last_good.err, last_good.data, last_good.cnt);
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (sbq.size() != 0 && t < budget) begin
      @(posedge clock);
      t++;
    end
    chk("drain_pending", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.status_valid), 32'd0);
    chk({tag, "_id"},    32'(bus.status_id), 32'd0);
    chk({tag, "_err"},   32'(bus.status_error), 32'd0);
    chk({tag, "_data"},  bus.status_data, 32'd0);
    chk({tag, "_count"}, 32'(bus.status_param_count), 32'd0);
    chk({tag, "_crc"},   32'(bus.crc_error), 32'd0);
    chk({tag, "_frame"}, 32'(bus.frame_error), 32'd0);
    chk({tag, "_to"},    32'(bus.timeout), 32'd0);
  endtask

  task automatic mk_ping();
    pkt = {8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h55, 8'h00, 8'h06, 8'h04, 8'h26};
    seal(1'b0);
  endtask

  task automatic mk_read(input logic corrupt);
    pkt = {8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h08, 8'h00, 8'h55, 8'h00,
           8'hA6, 8'h00, 8'h00, 8'h00};
    seal(corrupt);
  endtask

  task automatic ping_ok();
    mk_ping();
    expect_pulse(K_VALID, 8'h01, 8'h00, 32'h0026_0406, 8'd3);
    send_pkt(pkt.size(), -1);
    wait_drain(8 * CPB);
  endtask

  // Every pulse must match the next queued expectation, including the status payload.
  always @(negedge clock) begin
    logic [3:0] k;
    k = {bus.status_valid, bus.crc_error, bus.frame_error, bus.timeout};
    if (k != 4'b0000) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", 32'(k), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("pulse_kind",  32'(k), 32'(mon_e.kind));
        chk("status_id",   32'(bus.status_id), 32'(mon_e.id));
        chk("status_err",  32'(bus.status_error), 32'(mon_e.err));
        chk("status_data", bus.status_data, mon_e.data);
        chk("param_count", 32'(bus.status_param_count), 32'(mon_e.cnt));
      end
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    last_good.kind = 4'd0; last_good.id = 8'd0; last_good.err = 8'd0;
    last_good.data = 32'd0; last_good.cnt = 8'd0;

    reset = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk_zero("reset");
    @(posedge clock);
    reset = 1'b0;
    repeat (4 * CPB) @(posedge clock);

    ping_ok();

    mk_read(1'b0);
    expect_pulse(K_VALID, 8'h01, 8'h00, 32'h0000_00A6, 8'd4);
    send_pkt(pkt.size(), -1);
    wait_drain(8 * CPB);

    mk_read(1'b1);
    expect_hold(K_CRC);
    send_pkt(pkt.size(), -1);
    wait_drain(8 * CPB);

    // Raw FF FF FD FD 12: the second FD is a stuffing byte.
    pkt = {8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h02, 8'h09, 8'h00, 8'h55, 8'h00,
           8'hFF, 8'hFF, 8'hFD, 8'hFD, 8'h12};
    seal(1'b0);
    expect_pulse(K_VALID, 8'h02, 8'h00, 32'h12FD_FFFF, 8'd4);
    send_pkt(pkt.size(), -1);
    wait_drain(8 * CPB);

    mk_ping();
    expect_hold(K_FRAME);
    send_pkt(pkt.size(), 5);
    wait_drain(8 * CPB);
    ping_ok();

    mk_ping();
    expect_hold(K_TO);
    send_pkt(8, -1);
    wait_drain(TOC + 200);
    ping_ok();

    // LEN below 4 and above MAX_LEN abort without any pulse.
    pkt = {8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h03, 8'h03, 8'h00, 8'h55, 8'h00};
    send_pkt(pkt.size(), -1);
    pkt = {8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h03, 8'h2D, 8'h01, 8'h55, 8'h00};
    send_pkt(pkt.size(), -1);
    repeat (TOC + 100) @(posedge clock);
    ping_ok();

    // Back-to-back packets with no idle gap.
    mk_ping();
    tmp = pkt;
    mk_read(1'b0);
    pkt = {tmp, pkt};
    expect_pulse(K_VALID, 8'h01, 8'h00, 32'h0026_0406, 8'd3);
    expect_pulse(K_VALID, 8'h01, 8'h00, 32'h0000_00A6, 8'd4);
    send_pkt(pkt.size(), -1);
    wait_drain(8 * CPB);

    pkt = {8'hFF, 8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h05, 8'h00, 8'h01, 8'h55, 8'h00,
           8'h11, 8'h22, 8'h33};
    send_pkt(pkt.size(), -1);
    @(posedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk_zero("midreset");
    @(posedge clock);
    reset = 1'b0;
    repeat (4 * CPB) @(posedge clock);
    @(negedge clock);
    chk_zero("postreset");
    last_good.id = 8'd0; last_good.err = 8'd0; last_good.data = 32'd0; last_good.cnt = 8'd0;
    ping_ok();

    repeat (4 * CPB) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
